// File: rtl/instr_encoder_loader_pkg.sv
// RV32I opcode constants, instruction formats and loader FSM states shared by
// the encoder loader and its word encoder.
package rv_isa_pkg;

    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_I     = 7'b0010011;
    localparam logic [6:0] OP_LOAD  = 7'b0000011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;
    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_JALR  = 7'b1100111;

    typedef enum logic [2:0] {
        FMT_R,
        FMT_I,
        FMT_S,
        FMT_B,
        FMT_U,
        FMT_J,
        FMT_ILL
    } fmt_t;

    typedef enum logic [1:0] {
        IDLE,
        ENCODE,
        WRITE
    } loader_state_t;

    typedef struct packed {
        logic [6:0]  opcode;
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic [31:0] imm;
        logic        last;
    } instr_fields_t;

    // LOAD and JALR share the I-type layout.
    function automatic fmt_t opcode_fmt(input logic [6:0] op);
        fmt_t fmt;
        case (op)
            OP_R:                     fmt = FMT_R;
            OP_I, OP_LOAD, OP_JALR:   fmt = FMT_I;
            OP_S:                     fmt = FMT_S;
            OP_B:                     fmt = FMT_B;
            OP_LUI, OP_AUIPC:         fmt = FMT_U;
            OP_JAL:                   fmt = FMT_J;
            default:                  fmt = FMT_ILL;
        endcase
        return fmt;
    endfunction

endpackage

// File: rtl/instr_encoder_loader_if.sv
// Bus bundles for the loader: decoded-field input handshake and the
// instruction-memory write/ack port.
interface instr_fields_if;

    logic        IN_VALID;
    logic        IN_READY;
    logic [6:0]  OPCODE;
    logic [4:0]  RD;
    logic [4:0]  RS1;
    logic [4:0]  RS2;
    logic [2:0]  FUNCT3;
    logic [6:0]  FUNCT7;
    logic [31:0] IMM;
    logic        LAST;

    modport master (
        output IN_VALID, OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM, LAST,
        input  IN_READY
    );

    modport slave (
        input  IN_VALID, OPCODE, RD, RS1, RS2, FUNCT3, FUNCT7, IMM, LAST,
        output IN_READY
    );

endinterface

interface imem_wr_if #(
    parameter int unsigned ADDR_W = 10
);

    logic              MEM_WE;
    logic [ADDR_W-1:0] MEM_ADDR;
    logic [31:0]       MEM_WDATA;
    logic              MEM_ACK;

    modport master (
        output MEM_WE, MEM_ADDR, MEM_WDATA,
        input  MEM_ACK
    );

    modport slave (
        input  MEM_WE, MEM_ADDR, MEM_WDATA,
        output MEM_ACK
    );

endinterface

// File: rtl/instr_encoder_loader_word_encoder.sv
// Combinational RV32I field-to-word encoder; flags unknown opcodes and
// misaligned branch/jump offsets as illegal.
module instr_word_encoder
    import rv_isa_pkg::*;
(
    input  logic [6:0]  opcode,
    input  logic [4:0]  rd,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic [31:0] imm,
    output logic [31:0] word,
    output logic        illegal
);

    fmt_t fmt;

    assign fmt = opcode_fmt(opcode);

    always_comb begin
        word    = '0;
        illegal = 1'b0;
        unique case (fmt)
            FMT_R: word = {funct7, rs2, rs1, funct3, rd, opcode};
            FMT_I: word = {imm[11:0], rs1, funct3, rd, opcode};
            FMT_S: word = {imm[11:5], rs2, rs1, funct3, imm[4:0], opcode};
            FMT_B: begin
                word    = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], opcode};
                illegal = imm[0];
            end
            FMT_U: word = {imm[31:12], rd, opcode};
            FMT_J: begin
                word    = {imm[20], imm[10:1], imm[11], imm[19:12], rd, opcode};
                illegal = imm[0];
            end
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/instr_encoder_loader.sv
// Program loader: accepts decoded RV32I fields, encodes them and writes the
// words sequentially into instruction memory, tracking count and status.
module instr_encoder_loader
    import rv_isa_pkg::*;
#(
    parameter int unsigned       ADDR_W    = 10,
    parameter logic [ADDR_W-1:0] BASE_ADDR = '0,
    parameter int unsigned       DEPTH     = 256,
    localparam int unsigned      CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             START,
    instr_fields_if.slave    fields,
    imem_wr_if.master        mem,
    output logic [CNT_W-1:0] COUNT,
    output logic             FULL,
    output logic             DONE,
    output logic             ERROR
);

    localparam logic [CNT_W-1:0] DEPTH_C = CNT_W'(DEPTH);

    loader_state_t     state_q, state_d;
    instr_fields_t     fld_q, fld_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [31:0]       wdata_q, wdata_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic              full_q, full_d;
    logic              done_q, done_d;
    logic              error_q, error_d;

    logic              in_ready;
    logic [31:0]       enc_word;
    logic              enc_illegal;
    logic [CNT_W-1:0]  count_inc;

    instr_word_encoder u_enc (
        .opcode  (fld_q.opcode),
        .rd      (fld_q.rd),
        .rs1     (fld_q.rs1),
        .rs2     (fld_q.rs2),
        .funct3  (fld_q.funct3),
        .funct7  (fld_q.funct7),
        .imm     (fld_q.imm),
        .word    (enc_word),
        .illegal (enc_illegal)
    );

    // START takes priority over a simultaneous IN_VALID by masking ready.
    assign in_ready  = (state_q == IDLE) && !RESET && !START && !full_q && !done_q;
    assign count_inc = count_q + CNT_W'(1);

    always_comb begin
        state_d = state_q;
        fld_d   = fld_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        count_d = count_q;
        full_d  = full_q;
        done_d  = done_q;
        error_d = error_q;
        unique case (state_q)
            IDLE: begin
                if (START) begin
                    addr_d  = BASE_ADDR;
                    count_d = '0;
                    full_d  = 1'b0;
                    done_d  = 1'b0;
                    error_d = 1'b0;
                end else if (fields.IN_VALID && in_ready) begin
                    fld_d.opcode = fields.OPCODE;
                    fld_d.rd     = fields.RD;
                    fld_d.rs1    = fields.RS1;
                    fld_d.rs2    = fields.RS2;
                    fld_d.funct3 = fields.FUNCT3;
                    fld_d.funct7 = fields.FUNCT7;
                    fld_d.imm    = fields.IMM;
                    fld_d.last   = fields.LAST;
                    state_d      = ENCODE;
                end
            end
            ENCODE: begin
                if (enc_illegal) begin
                    error_d = 1'b1;
                    state_d = IDLE;
                end else begin
                    wdata_d = enc_word;
                    we_d    = 1'b1;
                    state_d = WRITE;
                end
            end
            WRITE: begin
                if (mem.MEM_ACK) begin
                    we_d    = 1'b0;
                    addr_d  = addr_q + ADDR_W'(4);
                    count_d = count_inc;
                    if (count_inc == DEPTH_C) full_d = 1'b1;
                    if (fld_q.last) done_d = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= IDLE;
            fld_q   <= '0;
            we_q    <= 1'b0;
            addr_q  <= BASE_ADDR;
            wdata_q <= '0;
            count_q <= '0;
            full_q  <= 1'b0;
            done_q  <= 1'b0;
            error_q <= 1'b0;
        end else begin
            state_q <= state_d;
            fld_q   <= fld_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            count_q <= count_d;
            full_q  <= full_d;
            done_q  <= done_d;
            error_q <= error_d;
        end
    end

    assign fields.IN_READY = in_ready;
    assign mem.MEM_WE      = we_q;
    assign mem.MEM_ADDR    = addr_q;
    assign mem.MEM_WDATA   = wdata_q;
    assign COUNT           = count_q;
    assign FULL            = full_q;
    assign DONE            = done_q;
    assign ERROR           = error_q;

endmodule

// File: tb/tb_instr_encoder_loader.sv
// Directed self-checking bench for instr_encoder_loader with hand-encoded
// RV32I words; small DEPTH and a high base address exercise FULL and wrap.
module tb_instr_encoder_loader;
    import rv_isa_pkg::*;

    localparam logic [31:0] BASE = 32'h3F0;

    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic [2:0] count;
    logic       full, done, error;

    int n_checks = 0;
    int n_pass   = 0;

    instr_fields_if          f_if ();
    imem_wr_if #(.ADDR_W(10)) m_if ();

    instr_encoder_loader #(
        .ADDR_W    (10),
        .BASE_ADDR (10'h3F0),
        .DEPTH     (4)
    ) dut (
        .CLK    (clk),
        .RESET  (rst),
        .START  (start),
        .fields (f_if),
        .mem    (m_if),
        .COUNT  (count),
        .FULL   (full),
        .DONE   (done),
        .ERROR  (error)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    endtask

    task automatic set_fields(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                              input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                              input logic [31:0] imm, input logic last);
        f_if.OPCODE = op;
        f_if.RD     = rd;
        f_if.RS1    = rs1;
        f_if.RS2    = rs2;
        f_if.FUNCT3 = f3;
        f_if.FUNCT7 = f7;
        f_if.IMM    = imm;
        f_if.LAST   = last;
    endtask

    // Returns just after the accepting clock edge.
    task automatic send(input logic [6:0] op, input logic [4:0] rd, input logic [4:0] rs1,
                        input logic [4:0] rs2, input logic [2:0] f3, input logic [6:0] f7,
                        input logic [31:0] imm, input logic last);
        int n;
        n = 0;
        @(negedge clk);
        set_fields(op, rd, rs1, rs2, f3, f7, imm, last);
        f_if.IN_VALID = 1'b1;
        while (!f_if.IN_READY && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("accept_wait", 32'(n < 20), 32'd1);
        @(posedge clk);
        #1 f_if.IN_VALID = 1'b0;
    endtask

    task automatic expect_write(input string tag, input logic [31:0] exp_addr,
                                input logic [31:0] exp_data, input int unsigned delay,
                                input bit start_mid);
        int n;
        int bad;
        logic [31:0] a0, d0;
        n   = 1;
        bad = 0;
        @(negedge clk);
        while (!m_if.MEM_WE && n < 20) begin
            @(negedge clk);
            n++;
        end
        check({tag, "_lat"}, 32'(n), 32'd2);
        check({tag, "_addr"}, 32'(m_if.MEM_ADDR), exp_addr);
        check({tag, "_data"}, m_if.MEM_WDATA, exp_data);
        a0 = 32'(m_if.MEM_ADDR);
        d0 = m_if.MEM_WDATA;
        for (int i = 0; i < int'(delay); i++) begin
            start = (start_mid && i == 1);
            @(negedge clk);
            if (m_if.MEM_WE !== 1'b1 || 32'(m_if.MEM_ADDR) !== a0 || m_if.MEM_WDATA !== d0) bad++;
        end
        start = 1'b0;
        if (delay > 0) check({tag, "_stable"}, 32'(bad), 32'd0);
        m_if.MEM_ACK = 1'b1;
        @(posedge clk);
        #1 m_if.MEM_ACK = 1'b0;
        @(negedge clk);
        check({tag, "_we_drop"}, 32'(m_if.MEM_WE), 32'd0);
    endtask

    task automatic watch_no_write(input string tag, input int unsigned cycles);
        int rose;
        rose = 0;
        for (int i = 0; i < int'(cycles); i++) begin
            @(negedge clk);
            if (m_if.MEM_WE !== 1'b0) rose = 1;
        end
        check(tag, 32'(rose), 32'd0);
    endtask

    task automatic pulse_start();
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1 start = 1'b0;
    endtask

    initial begin
        rst = 1'b1;
        start = 1'b0;
        f_if.IN_VALID = 1'b0;
        set_fields('0, '0, '0, '0, '0, '0, '0, 1'b0);
        m_if.MEM_ACK = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_ready", 32'(f_if.IN_READY), 32'd0);
        check("rst_we", 32'(m_if.MEM_WE), 32'd0);
        check("rst_addr", 32'(m_if.MEM_ADDR), BASE);
        check("rst_wdata", m_if.MEM_WDATA, 32'd0);
        check("rst_flags", {28'd0, full, done, error, 1'b0} | 32'(count), 32'd0);
        rst = 1'b0;
        #1 check("ready_after_rst", 32'(f_if.IN_READY), 32'd1);

        // add x3,x1,x2 with ack tied high
        m_if.MEM_ACK = 1'b1;
        send(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        expect_write("t1", BASE, 32'h002081B3, 0, 1'b0);
        check("t1_count", 32'(count), 32'd1);
        check("t1_addr_next", 32'(m_if.MEM_ADDR), BASE + 4);

        // addi / sw / lui back to back
        pulse_start();
        send(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        expect_write("t2_addi", BASE, 32'h00500093, 0, 1'b0);
        send(OP_S, 5'd0, 5'd1, 5'd2, 3'd2, 7'd0, 32'd12, 1'b0);
        expect_write("t2_sw", BASE + 4, 32'h0020A623, 0, 1'b0);
        send(OP_LUI, 5'd5, 5'd0, 5'd0, 3'd0, 7'd0, 32'h12345000, 1'b0);
        expect_write("t2_lui", BASE + 8, 32'h123452B7, 0, 1'b0);
        check("t2_count", 32'(count), 32'd3);
        check("t2_full", 32'(full), 32'd0);

        // beq then jal with LAST
        pulse_start();
        send(OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd8, 1'b0);
        expect_write("t3_beq", BASE, 32'h00208463, 0, 1'b0);
        send(OP_JAL, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd16, 1'b1);
        expect_write("t3_jal", BASE + 4, 32'h010000EF, 0, 1'b0);
        check("t3_done", 32'(done), 32'd1);
        check("t3_ready", 32'(f_if.IN_READY), 32'd0);
        set_fields(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        f_if.IN_VALID = 1'b1;
        watch_no_write("t3_blocked", 5);
        f_if.IN_VALID = 1'b0;
        check("t3_count", 32'(count), 32'd2);

        // START and IN_VALID together: START wins
        @(negedge clk);
        start = 1'b1;
        f_if.IN_VALID = 1'b1;
        #1 check("t3_start_ready", 32'(f_if.IN_READY), 32'd0);
        @(posedge clk);
        #1 begin
            start = 1'b0;
            f_if.IN_VALID = 1'b0;
        end
        watch_no_write("t3_start_wins", 4);
        check("t3_done_clr", 32'(done), 32'd0);
        check("t3_count_clr", 32'(count), 32'd0);
        check("t3_addr_base", 32'(m_if.MEM_ADDR), BASE);

        // delayed ack with a START pulse during WRITE
        send(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        expect_write("t4", BASE, 32'h002081B3, 5, 1'b1);
        watch_no_write("t4_single", 3);
        check("t4_count", 32'(count), 32'd1);
        check("t4_addr", 32'(m_if.MEM_ADDR), BASE + 4);

        // illegal opcode and misaligned branch
        send(7'h7F, 5'd1, 5'd1, 5'd1, 3'd0, 7'd0, 32'd0, 1'b0);
        watch_no_write("t5_ill_nowr", 4);
        check("t5_ill_err", 32'(error), 32'd1);
        check("t5_ill_count", 32'(count), 32'd1);
        send(OP_B, 5'd0, 5'd1, 5'd2, 3'd0, 7'd0, 32'd7, 1'b0);
        watch_no_write("t5_b_nowr", 4);
        check("t5_b_count", 32'(count), 32'd1);
        send(OP_I, 5'd1, 5'd0, 5'd0, 3'd0, 7'd0, 32'd5, 1'b0);
        expect_write("t5_ok", BASE + 4, 32'h00500093, 0, 1'b0);
        check("t5_err_sticky", 32'(error), 32'd1);
        check("t5_count", 32'(count), 32'd2);

        // reset in WRITE drops the pending write
        send(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        @(negedge clk);
        @(negedge clk);
        check("rw_we_pre", 32'(m_if.MEM_WE), 32'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rw_we", 32'(m_if.MEM_WE), 32'd0);
        check("rw_wdata", m_if.MEM_WDATA, 32'd0);
        check("rw_addr", 32'(m_if.MEM_ADDR), BASE);
        check("rw_count", 32'(count), 32'd0);
        check("rw_error", 32'(error), 32'd0);
        check("rw_ready", 32'(f_if.IN_READY), 32'd0);
        rst = 1'b0;
        watch_no_write("rw_dropped", 4);
        pulse_start();
        @(negedge clk);
        check("rw_start_addr", 32'(m_if.MEM_ADDR), BASE);

        // fill to DEPTH=4, address wraps past 0x3FC
        send(OP_LOAD, 5'd4, 5'd2, 5'd0, 3'd2, 7'd0, 32'hFFFFFFFC, 1'b0);
        expect_write("t6_lw", BASE, 32'hFFC12203, 0, 1'b0);
        send(OP_AUIPC, 5'd7, 5'd0, 5'd0, 3'd0, 7'd0, 32'hABCDE000, 1'b0);
        expect_write("t6_auipc", BASE + 4, 32'hABCDE397, 0, 1'b0);
        send(OP_JALR, 5'd0, 5'd1, 5'd0, 3'd0, 7'd0, 32'd0, 1'b0);
        expect_write("t6_jalr", BASE + 8, 32'h00008067, 0, 1'b0);
        check("t6_full_early", 32'(full), 32'd0);
        send(OP_B, 5'd0, 5'd3, 5'd4, 3'd1, 7'd0, 32'hFFFFFFFC, 1'b0);
        expect_write("t6_bne", BASE + 12, 32'hFE419EE3, 0, 1'b0);
        check("t6_full", 32'(full), 32'd1);
        check("t6_count", 32'(count), 32'd4);
        check("t6_ready", 32'(f_if.IN_READY), 32'd0);
        check("t6_wrap", 32'(m_if.MEM_ADDR), 32'd0);
        set_fields(OP_R, 5'd3, 5'd1, 5'd2, 3'd0, 7'd0, 32'd0, 1'b0);
        f_if.IN_VALID = 1'b1;
        watch_no_write("t6_blocked", 5);
        f_if.IN_VALID = 1'b0;

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
